product_accumulator: RTL and testbench

- Downstream stage of the 5x5 Wallace tree multiplier; consumes its 10-bit product P, one beat per valid/ready handshake.
- Sums a burst of products into a wide accumulator. A burst closes on in_last or after MAX_TERMS beats.
- Presents the registered sum, term count and overflow flag on a valid/ready output port.
- Forms the accumulate half of the team's multiply-accumulate datapath.

---
 rtl/product_accumulator_if.sv | 30 +++
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Product-beat input port and burst-result output port of the product accumulator.
// master = producer/consumer side, slave = accumulator.
interface product_accumulator_if #(
    parameter int PROD_W    = 10,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 8
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CW-1:0]     out_count;
    logic              out_ovf;

    modport master (
        output clear, in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a burst of unsigned multiplier products into a saturating accumulator, one result per burst.
// Latency: closing beat accepted at edge N -> out_valid high after edge N.
// Backpressure: in_ready low while a result is held; input stalls until the result is taken.
module product_accumulator #(
    parameter int PROD_W    = 10,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    product_accumulator_if.slave      bus
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CW-1:0]    count;
        logic             ovf;
    } res_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_vld_q, out_vld_d;
    res_t             res_q, res_d;

    logic             beat_acc;
    logic             closing;
    logic [ACC_W:0]   nsum;
    logic [ACC_W-1:0] acc_nx;
    logic [CW-1:0]    cnt_nx;
    logic             ovf_nx;

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_vld_q;
    assign bus.out_sum   = res_q.sum;
    assign bus.out_count = res_q.count;
    assign bus.out_ovf   = res_q.ovf;

    // One extra bit on the adder exposes the carry used for saturation.
    assign beat_acc = bus.in_valid && (state_q == ACCUM) && !bus.clear;
    assign nsum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
    assign acc_nx   = nsum[ACC_W] ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
    assign ovf_nx   = ovf_q | nsum[ACC_W];
    assign cnt_nx   = cnt_q + CW'(1);
    assign closing  = beat_acc && (bus.in_last || (cnt_nx == CW'(MAX_TERMS)));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;
        res_d     = res_q;

        if (bus.clear) begin
            // Abort wins over both a coincident beat and a coincident result pickup.
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_acc) begin
                        acc_d = acc_nx;
                        cnt_d = cnt_nx;
                        ovf_d = ovf_nx;
                        if (closing) begin
                            res_d.sum   = acc_nx;
                            res_d.count = cnt_nx;
                            res_d.ovf   = ovf_nx;
                            out_vld_d   = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_vld_q && bus.out_ready) begin
                        out_vld_d = 1'b0;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default build (ACC_W=16) plus a narrow build (ACC_W=12)
// for saturation; expected values are hand-computed constants.
module tb_product_accumulator;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    product_accumulator_if #(.PROD_W(10), .ACC_W(16), .MAX_TERMS(8)) bus_a ();
    product_accumulator_if #(.PROD_W(10), .ACC_W(12), .MAX_TERMS(8)) bus_b ();

    product_accumulator #(.PROD_W(10), .ACC_W(16), .MAX_TERMS(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    product_accumulator #(.PROD_W(10), .ACC_W(12), .MAX_TERMS(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one beat into DUT A for one edge, then return 1 time unit after it.
    task automatic beat_a(input logic [9:0] p, input logic last);
        bus_a.in_valid = 1'b1;
        bus_a.in_prod  = p;
        bus_a.in_last  = last;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic beat_b(input logic [9:0] p, input logic last);
        bus_b.in_valid = 1'b1;
        bus_b.in_prod  = p;
        bus_b.in_last  = last;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        bus_b.in_last  = 1'b0;
    endtask

    task automatic take_a(input string tag);
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, bus_a.out_valid, 0);
        chk({tag, "_rdy_back"}, bus_a.in_ready, 1);
    endtask

    task automatic check_res_a(input string tag, input int sum, input int cnt, input int ovf);
        chk({tag, "_vld"}, bus_a.out_valid, 1);
        chk({tag, "_sum"}, bus_a.out_sum, sum);
        chk({tag, "_cnt"}, bus_a.out_count, cnt);
        chk({tag, "_ovf"}, bus_a.out_ovf, ovf);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus_a.clear = 0; bus_a.in_valid = 0; bus_a.in_prod = '0; bus_a.in_last = 0; bus_a.out_ready = 0;
        bus_b.clear = 0; bus_b.in_valid = 0; bus_b.in_prod = '0; bus_b.in_last = 0; bus_b.out_ready = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", bus_a.out_valid, 0);
        chk("rst_sum", bus_a.out_sum, 0);
        chk("rst_cnt", bus_a.out_count, 0);
        chk("rst_ovf", bus_a.out_ovf, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy", bus_a.in_ready, 1);

        // Reset mid-burst: 100+200 must be forgotten.
        beat_a(10'd100, 1'b0);
        beat_a(10'd200, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", bus_a.out_valid, 0);
        chk("mid_rst_sum", bus_a.out_sum, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdy", bus_a.in_ready, 1);
        beat_a(10'd7, 1'b1);
        check_res_a("after_rst", 7, 1, 0);
        take_a("after_rst");

        // Basic three-beat burst.
        beat_a(10'd3, 1'b0);
        beat_a(10'd10, 1'b0);
        chk("basic_not_yet", bus_a.out_valid, 0);
        beat_a(10'd961, 1'b1);
        check_res_a("basic", 974, 3, 0);
        chk("basic_hold_rdy", bus_a.in_ready, 0);
        take_a("basic");

        // Auto-close after MAX_TERMS beats with in_last never set.
        for (int i = 0; i < 7; i++) beat_a(10'd961, 1'b0);
        chk("auto_7_vld", bus_a.out_valid, 0);
        chk("auto_7_rdy", bus_a.in_ready, 1);
        beat_a(10'd961, 1'b0);
        check_res_a("auto", 7688, 8, 0);
        take_a("auto");

        // in_last coinciding with the MAX_TERMS beat closes exactly once.
        for (int i = 0; i < 7; i++) beat_a(10'd1, 1'b0);
        beat_a(10'd1, 1'b1);
        check_res_a("last_at_max", 8, 8, 0);
        take_a("last_at_max");

        // Back-pressure: hold result while a beat is offered.
        beat_a(10'd20, 1'b1);
        bus_a.in_valid = 1'b1;
        bus_a.in_prod  = 10'd50;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", bus_a.out_valid, 1);
            chk("bp_sum", bus_a.out_sum, 20);
            chk("bp_rdy", bus_a.in_ready, 0);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        chk("bp_drop", bus_a.out_valid, 0);
        chk("bp_rdy_back", bus_a.in_ready, 1);
        beat_a(10'd50, 1'b1);
        check_res_a("bp_next", 50, 1, 0);
        take_a("bp_next");

        // Clear drops a coincident beat and the partial burst.
        beat_a(10'd100, 1'b0);
        beat_a(10'd200, 1'b0);
        bus_a.clear    = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_prod  = 10'd400;
        @(posedge clk); #1;
        bus_a.clear    = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("clr_vld", bus_a.out_valid, 0);
        chk("clr_rdy", bus_a.in_ready, 1);
        beat_a(10'd5, 1'b1);
        check_res_a("clr_next", 5, 1, 0);

        // Clear in HOLD together with out_ready.
        bus_a.clear     = 1'b1;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.clear     = 1'b0;
        bus_a.out_ready = 1'b0;
        chk("clr_hold_vld", bus_a.out_valid, 0);
        chk("clr_hold_rdy", bus_a.in_ready, 1);
        beat_a(10'd9, 1'b1);
        check_res_a("clr_hold_next", 9, 1, 0);
        take_a("clr_hold_next");

        // Saturation on the 12-bit build: 5*961 = 4805 > 4095.
        for (int i = 0; i < 4; i++) beat_b(10'd961, 1'b0);
        chk("sat_4_vld", bus_b.out_valid, 0);
        beat_b(10'd961, 1'b1);
        chk("sat_vld", bus_b.out_valid, 1);
        chk("sat_sum", bus_b.out_sum, 4095);
        chk("sat_cnt", bus_b.out_count, 5);
        chk("sat_ovf", bus_b.out_ovf, 1);
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
        chk("sat_drop", bus_b.out_valid, 0);
        beat_b(10'd1, 1'b1);
        chk("sat_next_sum", bus_b.out_sum, 1);
        chk("sat_next_cnt", bus_b.out_count, 1);
        chk("sat_next_ovf", bus_b.out_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
